// File: rtl/des_key_sched_stream_if.sv
// Key-in / subkey-out stream bundle for des_key_sched_stream.
// master drives keys and consumes beats; slave is the key scheduler.
interface des_key_sched_stream_if #(
   parameter int unsigned KPC = 1
) ();
   logic              in_valid;
   logic              in_ready;
   logic [1:64]       key_in;
   logic              encrypt;
   logic              abort;
   logic              out_valid;
   logic              out_ready;
   logic [1:48*KPC]   subkeys_out;
   logic [3:0]        round_idx;
   logic              out_last;
   logic              busy;

   modport master (
      output in_valid, key_in, encrypt, abort, out_ready,
      input  in_ready, out_valid, subkeys_out, round_idx, out_last, busy
   );

   modport slave (
      input  in_valid, key_in, encrypt, abort, out_ready,
      output in_ready, out_valid, subkeys_out, round_idx, out_last, busy
   );
endinterface

// File: rtl/des_key_sched_stream.sv
// Sequential DES key schedule streaming KPC subkeys per beat in encrypt or decrypt order.
// Optional key parity check enabled by defining DES_KS_PARITY_CHK_EN.
module des_key_sched_stream #(
   parameter int unsigned KPC = 1
) (
   input  logic clk,
   input  logic rst_n,
`ifdef DES_KS_PARITY_CHK_EN
   output logic parity_err,
`endif
   des_key_sched_stream_if.slave bus
);

   localparam int unsigned BEATS = 16 / KPC;
   localparam int unsigned KSH   = $clog2(KPC);

   if (KPC != 1 && KPC != 2 && KPC != 4 && KPC != 8 && KPC != 16) begin : gen_kpc_chk
      $error("des_key_sched_stream: KPC must be 1, 2, 4, 8 or 16");
   end

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   typedef enum logic {StIdle, StRun} state_e;

   function automatic logic [1:56] pc1_perm(input logic [1:64] k);
      logic [1:56] r;
      for (int i = 0; i < 56; i++) r[i+1] = k[PC1[i]];
      return r;
   endfunction

   function automatic logic [1:48] pc2_perm(input logic [1:56] cd);
      logic [1:48] r;
      for (int i = 0; i < 48; i++) r[i+1] = cd[PC2[i]];
      return r;
   endfunction

   // Rotate each 28-bit half: left for encrypt, right for decrypt, by 1 or 2.
   function automatic logic [1:28] half_rot(input logic [1:28] h, input logic dec,
                                            input logic two);
      case ({dec, two})
         2'b00:   return {h[2:28], h[1]};
         2'b01:   return {h[3:28], h[1:2]};
         2'b10:   return {h[28], h[1:27]};
         default: return {h[27:28], h[1:26]};
      endcase
   endfunction

   function automatic logic [1:56] cd_rot(input logic [1:56] cd, input logic dec,
                                          input logic two);
      return {half_rot(cd[1:28], dec, two), half_rot(cd[29:56], dec, two)};
   endfunction

   // Table index q holds the shift for round q+1; single shifts at rounds 1, 2, 9, 16.
   function automatic logic one_shift(input logic [3:0] q);
      return (q == 4'd0) || (q == 4'd1) || (q == 4'd8) || (q == 4'd15);
   endfunction

   // Advance from stream position p to p+1.
   function automatic logic [1:56] cd_step(input logic [1:56] cd, input logic dec,
                                           input logic [3:0] p);
      logic two;
      two = dec ? !one_shift(~p) : !one_shift(p + 4'd1);
      return cd_rot(cd, dec, two);
   endfunction

   state_e       state_q, state_d;
   logic [1:56]  cd_q, cd_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         dec_q, dec_d;
   logic         rdy_q;
   logic [3:0]   pos_base;
   logic [1:56]  cd_adv;
   logic [1:48*KPC] subkeys;
   logic         run;
   logic         last;
   logic         accept;

   assign run      = (state_q == StRun);
   assign pos_base = cnt_q << KSH;
   assign last     = run && (cnt_q == 4'(BEATS - 1));
   assign accept   = (state_q == StIdle) && rdy_q && bus.in_valid;

   always_comb begin : slice_chain
      logic [1:56] cur;
      logic [3:0]  p;
      cur     = cd_q;
      p       = pos_base;
      subkeys = '0;
      for (int j = 0; j < KPC; j++) begin
         subkeys[48*j+1 +: 48] = pc2_perm(cur);
         cur = cd_step(cur, dec_q, p);
         p   = p + 4'd1;
      end
      cd_adv = cur;
   end

   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               // Encrypt starts at K1 (one left shift); decrypt starts at K16 (net 28 = none).
               cd_d    = bus.encrypt ? cd_rot(pc1_perm(bus.key_in), 1'b0, 1'b0)
                                     : pc1_perm(bus.key_in);
               dec_d   = !bus.encrypt;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (bus.abort) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else if (bus.out_ready) begin
               cd_d  = cd_adv;
               cnt_d = cnt_q + 4'd1;
               if (last) begin
                  cnt_d   = '0;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cd_q    <= '0;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         rdy_q   <= 1'b1;
      end
   end

   assign bus.in_ready    = (state_q == StIdle) && rdy_q;
   assign bus.out_valid   = run;
   assign bus.busy        = run;
   assign bus.out_last    = last;
   assign bus.round_idx   = run ? pos_base : 4'd0;
   assign bus.subkeys_out = run ? subkeys : '0;

`ifdef DES_KS_PARITY_CHK_EN
   logic perr_q;
   logic key_bad;

   // Every key byte must carry odd parity.
   always_comb begin
      key_bad = 1'b0;
      for (int b = 0; b < 8; b++) key_bad = key_bad | ~(^bus.key_in[8*b+1 +: 8]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_q <= 1'b0;
      end else if (accept) begin
         perr_q <= key_bad;
      end
   end

   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_des_key_sched_stream.sv
// Directed bench for des_key_sched_stream at KPC=1 and KPC=4 using the FIPS example key.
// Parity checks run when DES_KS_PARITY_CHK_EN is defined.
module tb_des_key_sched_stream;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_bad;
   logic [47:0] kexp [16];

   localparam logic [63:0] KEY_OK  = 64'h1334_5779_9BBC_DFF1;
   localparam logic [63:0] KEY_BAD = 64'h1334_5779_9BBC_DFF0;
   localparam logic [63:0] KEY_JNK = 64'hFFFF_0000_A5A5_0F0F;

   des_key_sched_stream_if #(.KPC(1)) if1 ();
   des_key_sched_stream_if #(.KPC(4)) if4 ();

`ifdef DES_KS_PARITY_CHK_EN
   logic perr1;
   logic perr4;
`endif

   des_key_sched_stream #(.KPC(1)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef DES_KS_PARITY_CHK_EN
      .parity_err (perr1),
`endif
      .bus        (if1)
   );

   des_key_sched_stream #(.KPC(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef DES_KS_PARITY_CHK_EN
      .parity_err (perr4),
`endif
      .bus        (if4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One KPC=1 job; stall randomises out_ready and holds a junk key on in_valid during RUN.
   task automatic job1(input logic enc, input logic [63:0] key, input bit stall,
                       input bit ab_acc, input bit exp_perr);
      int  b;
      int  cyc;
      int  e;
      bit  rdy;
      @(negedge clk);
      check("k1_idle_in_ready", 64'(if1.in_ready), 64'd1);
      check("k1_idle_valid", 64'(if1.out_valid), 64'd0);
      if1.in_valid = 1'b1;
      if1.key_in   = key;
      if1.encrypt  = enc;
      if1.abort    = ab_acc;
      if1.out_ready = 1'b0;
      @(negedge clk);
      if1.abort = 1'b0;
      if (stall) begin
         if1.key_in  = KEY_JNK;
         if1.encrypt = ~enc;
      end else begin
         if1.in_valid = 1'b0;
      end
      check("k1_latency_valid", 64'(if1.out_valid), 64'd1);
      b   = 0;
      cyc = 0;
      while (b < 16) begin
         if (cyc == 400) begin
            check("k1_timeout_beats", 64'(b), 64'd16);
            break;
         end
         e = enc ? b : 15 - b;
         check("k1_valid", 64'(if1.out_valid), 64'd1);
         check("k1_busy", 64'(if1.busy), 64'd1);
         check("k1_in_ready_run", 64'(if1.in_ready), 64'd0);
         check("k1_subkey", 64'(if1.subkeys_out), 64'(kexp[e]));
         check("k1_round_idx", 64'(if1.round_idx), 64'(b));
         check("k1_last", 64'(if1.out_last), 64'(b == 15));
`ifdef DES_KS_PARITY_CHK_EN
         check("k1_parity_err", 64'(perr1), 64'(exp_perr));
`endif
         rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if1.out_ready = rdy;
         @(negedge clk);
         if (rdy) b++;
         cyc++;
      end
      if1.out_ready = 1'b0;
      if1.in_valid  = 1'b0;
      check("k1_end_valid", 64'(if1.out_valid), 64'd0);
      check("k1_end_in_ready", 64'(if1.in_ready), 64'd1);
      check("k1_end_busy", 64'(if1.busy), 64'd0);
   endtask

   task automatic job4(input logic enc, input bit stall);
      int  b;
      int  cyc;
      int  e;
      bit  rdy;
      @(negedge clk);
      check("k4_idle_in_ready", 64'(if4.in_ready), 64'd1);
      if4.in_valid = 1'b1;
      if4.key_in   = KEY_OK;
      if4.encrypt  = enc;
      if4.out_ready = 1'b0;
      @(negedge clk);
      if4.in_valid = 1'b0;
      b   = 0;
      cyc = 0;
      while (b < 4) begin
         if (cyc == 200) begin
            check("k4_timeout_beats", 64'(b), 64'd4);
            break;
         end
         check("k4_valid", 64'(if4.out_valid), 64'd1);
         check("k4_round_idx", 64'(if4.round_idx), 64'(4 * b));
         check("k4_last", 64'(if4.out_last), 64'(b == 3));
         for (int j = 0; j < 4; j++) begin
            e = enc ? 4 * b + j : 15 - (4 * b + j);
            check("k4_slice", 64'(if4.subkeys_out[48*j+1 +: 48]), 64'(kexp[e]));
         end
         rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if4.out_ready = rdy;
         @(negedge clk);
         if (rdy) b++;
         cyc++;
      end
      if4.out_ready = 1'b0;
      check("k4_end_valid", 64'(if4.out_valid), 64'd0);
      check("k4_end_in_ready", 64'(if4.in_ready), 64'd1);
   endtask

   // Abort coincident with the handshake of beat 5, then restart.
   task automatic abort_mid;
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.key_in   = KEY_OK;
      if1.encrypt  = 1'b1;
      @(negedge clk);
      if1.in_valid  = 1'b0;
      if1.out_ready = 1'b1;
      repeat (5) @(negedge clk);
      check("ab_round_idx", 64'(if1.round_idx), 64'd5);
      check("ab_subkey", 64'(if1.subkeys_out), 64'(kexp[5]));
      if1.abort = 1'b1;
      @(negedge clk);
      if1.abort     = 1'b0;
      if1.out_ready = 1'b0;
      check("ab_valid", 64'(if1.out_valid), 64'd0);
      check("ab_in_ready", 64'(if1.in_ready), 64'd1);
      check("ab_round_idx_clr", 64'(if1.round_idx), 64'd0);
      job1(1'b0, KEY_OK, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic reset_mid;
      @(negedge clk);
      if1.in_valid = 1'b1;
      if1.key_in   = KEY_BAD;
      if1.encrypt  = 1'b1;
      @(negedge clk);
      if1.in_valid  = 1'b0;
      if1.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", 64'(if1.out_valid), 64'd0);
      check("rst_busy", 64'(if1.busy), 64'd0);
      check("rst_subkey", 64'(if1.subkeys_out), 64'd0);
      check("rst_round_idx", 64'(if1.round_idx), 64'd0);
      check("rst_last", 64'(if1.out_last), 64'd0);
`ifdef DES_KS_PARITY_CHK_EN
      check("rst_parity_err", 64'(perr1), 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_no_partial", 64'(if1.out_valid), 64'd0);
      if1.out_ready = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      kexp = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
               48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
               48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
               48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
      rst_n = 1'b0;
      if1.in_valid = 1'b0; if1.key_in = '0; if1.encrypt = 1'b0; if1.abort = 1'b0;
      if1.out_ready = 1'b0;
      if4.in_valid = 1'b0; if4.key_in = '0; if4.encrypt = 1'b0; if4.abort = 1'b0;
      if4.out_ready = 1'b0;

      @(negedge clk);
      check("reset_valid", 64'(if1.out_valid), 64'd0);
      check("reset_busy", 64'(if1.busy), 64'd0);
      check("reset_round_idx", 64'(if1.round_idx), 64'd0);
      check("reset_subkey", 64'(if1.subkeys_out), 64'd0);
      check("reset_last", 64'(if1.out_last), 64'd0);
      check("reset4_valid", 64'(if4.out_valid), 64'd0);
      check("reset4_subkeys", 64'(|if4.subkeys_out), 64'd0);
`ifdef DES_KS_PARITY_CHK_EN
      check("reset_parity_err", 64'(perr1), 64'd0);
`endif
      rst_n = 1'b1;

      job1(1'b1, KEY_OK, 1'b0, 1'b0, 1'b0);
      job1(1'b0, KEY_OK, 1'b0, 1'b0, 1'b0);
      job1(1'b1, KEY_OK, 1'b1, 1'b0, 1'b0);
      job1(1'b0, KEY_OK, 1'b1, 1'b1, 1'b0);
      abort_mid();
      job4(1'b1, 1'b0);
      job4(1'b0, 1'b0);
      job4(1'b1, 1'b1);
      reset_mid();
      // Parity bits are outside PC1, so the bad-parity key yields the same subkeys.
      job1(1'b1, KEY_BAD, 1'b0, 1'b0, 1'b1);
      job1(1'b1, KEY_OK, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/des_key_sched_stream.md
Name: des_key_sched_stream

Overview:
- Sequential DES key schedule that accepts one 64-bit key per job and streams the 16 round subkeys over a valid/ready interface.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).
- Parametrised to emit 1, 2, 4, 8 or 16 subkeys per output beat.
- Sits between the key register bank and the round datapath; replaces per-round combinational shift units.

Parameters:
- KPC, default 1: subkeys per beat. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- BEATS, default 16/KPC: derived, not overridable; number of output beats per key.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: key present.
- in_ready, output, 1: block can accept a key.
- key_in, input, [1:64]: DES key, bit 1 = MSB (FIPS numbering).
- encrypt, input, 1: 1 = encrypt order, 0 = decrypt order; sampled at accept.
- abort, input, 1: synchronous job cancel.
- out_valid, output, 1: subkey beat valid.
- out_ready, input, 1: consumer accepts beat.
- subkeys_out, output, [1:48*KPC]: KPC subkeys; earliest round in the MSB slice [1:48].
- round_idx, output, 4: stream position (0..15) of the first subkey in the beat.
- out_last, output, 1: final beat of the job.
- busy, output, 1: job in progress.

Behaviour:
- Reset (async, rst_n=0): state IDLE, C/D registers 0, beat counter 0, out_valid 0, out_last 0, round_idx 0, subkeys_out 0, busy 0. in_ready goes to 1 after reset release.
- States: IDLE, RUN.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: C/D <= PC1(key_in); mode <= encrypt; counter <= 0; go to RUN.
- RUN:
  - in_ready=0, busy=1, out_valid=1 from the cycle after accept (latency 1).
  - Output subkey j of beat b is PC2 of C/D after the cumulative rotation for stream position b*KPC+j.
- Encrypt rotation:
  - Left rotate of each 28-bit half before round r.
  - Shift amounts for r=1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt rotation:
  - Position 0 uses unrotated PC1 output.
  - Positions 1..15 right rotate by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Net result: K16 first, K1 last.
- Advance: on out_valid & out_ready, C/D <= state rotated by the sum of KPC shift amounts; counter++; round_idx = counter*KPC.
- out_last=1 when counter==BEATS-1. Handshake on the last beat returns the block to IDLE; out_valid deasserts the next cycle.
- Backpressure: while out_valid & !out_ready, subkeys_out, round_idx and out_last are held stable.
- Abort:
  - abort=1 in RUN returns the block to IDLE next cycle and clears the counter.
  - Abort takes priority over a simultaneous output handshake; that beat counts as not consumed.
  - abort in IDLE is ignored, including when coincident with an accept (accept proceeds).
- No key overlap: at least one IDLE cycle separates jobs.
- Reset mid-job: all state clears immediately; no partial beat is emitted after rst_n rises.
- in_valid during RUN is ignored and not captured.

Optional Feature:
- Macro: DES_KS_PARITY_CHK_EN.
- When defined:
  - Adds output port parity_err (1 bit, reset 0).
  - At accept, each key byte is checked for odd parity.
  - If any byte fails, parity_err=1 for RUN duration and the job streams normally.
  - parity_err clears at the next accept or on reset.
- When undefined: the port and logic are absent, and parity bits are ignored as in standard PC1.

Test Plan:
- KPC=1, encrypt=1, key 133457799BBCDFF1, out_ready=1 -> 16 beats; beat 0 = 1B02EFFC7072, beat 15 = CB3D8B0E17F5 with out_last=1; out_valid first high 1 cycle after accept.
- KPC=1, encrypt=0, same key -> beat 0 = CB3D8B0E17F5, round_idx 0; beat 15 = 1B02EFFC7072; sequence is exactly the reverse of the encrypt run.
- KPC=4, encrypt=1, same key -> 4 beats; beat 0 subkeys_out[1:48] = 1B02EFFC7072; beat 3 last slice = CB3D8B0E17F5; round_idx = 0,4,8,12.
- Random out_ready with ~50% stalls -> outputs stable during stalls; subkey sequence identical to the no-stall run; exactly 16/KPC handshakes.
- abort asserted on beat 5 coincident with handshake -> IDLE next cycle, in_ready=1. A new key is then accepted and restarts at round_idx 0.
- DES_KS_PARITY_CHK_EN defined:
  - key 133457799BBCDFF0 -> parity_err=1 throughout RUN.
  - key 133457799BBCDFF1 -> parity_err=0.
  - rst_n pulse mid-job -> all outputs 0 asynchronously.
